// File: rtl/proc_pkg.sv
// Shared types and constants for the 22-bit five-stage pipeline.
package proc_pkg;

  localparam int DATA_W    = 22;
  localparam int REG_W     = 4;
  localparam int MUL_STEPS = 11;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_MUL = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } ex_state_t;

  typedef struct packed {
    logic              pc_src;
    logic              reg_write;
    logic              mem_reg;
    logic              mem_write;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] write_data;
    logic [REG_W-1:0]  write_register;
  } ex_mem_t;

endpackage

// File: rtl/iterative_multiplier.sv
// Radix-4 shift-add multiplier: 2 multiplier bits per cycle, low DATA_W bits of the product.
module iterative_multiplier
  import proc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] pp;
  logic [3:0]        count_q;
  logic              busy_q;

  // Select 0/a/2a/3a from the low two multiplier bits; mcand_q is already pre-shifted.
  always_comb begin
    pp = '0;
    case (mplier_q[1:0])
      2'b00: pp = '0;
      2'b01: pp = mcand_q;
      2'b10: pp = mcand_q << 1;
      2'b11: pp = mcand_q + (mcand_q << 1);
      default: pp = '0;
    endcase
  end

  // Operand latches, accumulator and step counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
    end else if (abort) begin
      busy_q  <= 1'b0;
      count_q <= '0;
    end else if (start) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
      count_q  <= 4'(MUL_STEPS - 1);
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_q + pp;
      mcand_q  <= mcand_q << 2;
      mplier_q <= mplier_q >> 2;
      if (count_q == '0) busy_q  <= 1'b0;
      else               count_q <= count_q - 4'd1;
    end
  end

  assign busy    = busy_q;
  // High during the final step; product holds the full result from the next cycle.
  assign done    = busy_q && (count_q == '0);
  assign product = acc_q;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU, optional iterative MUL with stall FSM, EX/MEM register.
// Optional feature macro: EXEC_MUL_EN (multiplier + FSM); otherwise MUL yields 0 in one cycle.
module execute_stage
  import proc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_e,
  input  logic              flush_e,
  input  logic              pc_src_e,
  input  logic              reg_write_e,
  input  logic              mem_reg_e,
  input  logic              mem_write_e,
  input  logic [2:0]        alu_control_e,
  input  logic [DATA_W-1:0] src_a_e,
  input  logic [DATA_W-1:0] src_b_e,
  input  logic [DATA_W-1:0] write_data_e,
  input  logic [REG_W-1:0]  write_register_e,
  output logic              stall_e,
  output logic              zero_e,
  output logic              pc_src_m,
  output logic              reg_write_m,
  output logic              mem_reg_m,
  output logic              mem_write_m,
  output logic [DATA_W-1:0] alu_result_m,
  output logic [DATA_W-1:0] write_data_m,
  output logic [REG_W-1:0]  write_register_m
);

  alu_op_t           op;
  logic [DATA_W-1:0] add_sub;
  logic [DATA_W-1:0] alu_result;
  logic [4:0]        shamt;
  ex_mem_t           alu_slot;
  ex_mem_t           ex_mem_d;
  ex_mem_t           ex_mem_q;

  assign op    = alu_op_t'(alu_control_e);
  assign shamt = src_b_e[4:0];

  // Single-cycle ALU; MUL is handled by the multiplier path (or yields 0 without it).
  always_comb begin
    add_sub    = (op == ALU_SUB) ? (src_a_e - src_b_e) : (src_a_e + src_b_e);
    alu_result = '0;
    case (op)
      ALU_ADD, ALU_SUB: alu_result = add_sub;
      ALU_AND:          alu_result = src_a_e & src_b_e;
      ALU_OR:           alu_result = src_a_e | src_b_e;
      ALU_XOR:          alu_result = src_a_e ^ src_b_e;
      ALU_SLL:          alu_result = (shamt >= 5'(DATA_W)) ? '0 : (src_a_e << shamt);
      ALU_SRL:          alu_result = (shamt >= 5'(DATA_W)) ? '0 : (src_a_e >> shamt);
      default:          alu_result = '0;
    endcase
  end

  assign zero_e = ((op == ALU_ADD) || (op == ALU_SUB)) && (add_sub == '0);

  // Slot contents for an instruction retiring straight from the ALU.
  always_comb begin
    alu_slot                = '0;
    alu_slot.pc_src         = pc_src_e;
    alu_slot.reg_write      = reg_write_e;
    alu_slot.mem_reg        = mem_reg_e;
    alu_slot.mem_write      = mem_write_e;
    alu_slot.alu_result     = alu_result;
    alu_slot.write_data     = write_data_e;
    alu_slot.write_register = write_register_e;
  end

`ifdef EXEC_MUL_EN
  ex_state_t         state_q, state_d;
  ex_mem_t           mul_ctrl_q, mul_ctrl_d;
  logic              mul_start, mul_abort, mul_busy, mul_done;
  logic              stall;
  logic [DATA_W-1:0] mul_product;

  iterative_multiplier u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .abort   (mul_abort),
    .a       (src_a_e),
    .b       (src_b_e),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // FSM state and latched MUL control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mul_ctrl_q <= '0;
    end else begin
      state_q    <= state_d;
      mul_ctrl_q <= mul_ctrl_d;
    end
  end

  // Next-state, stall and EX/MEM slot selection; flush overrides everything.
  always_comb begin
    state_d    = state_q;
    mul_ctrl_d = mul_ctrl_q;
    mul_start  = 1'b0;
    mul_abort  = 1'b0;
    stall      = 1'b0;
    ex_mem_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (valid_e) begin
          if (op == ALU_MUL) begin
            mul_start             = 1'b1;
            stall                 = 1'b1;
            mul_ctrl_d            = alu_slot;
            mul_ctrl_d.alu_result = '0;
            state_d               = S_BUSY;
          end else begin
            ex_mem_d = alu_slot;
          end
        end
      end
      S_BUSY: begin
        stall = 1'b1;
        // Leaving on !mul_busy too keeps the FSM from hanging if the unit ever stops early.
        if (mul_done || !mul_busy) state_d = S_DONE;
      end
      S_DONE: begin
        ex_mem_d            = mul_ctrl_q;
        ex_mem_d.alu_result = mul_product;
        state_d             = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_e) begin
      state_d   = S_IDLE;
      mul_start = 1'b0;
      mul_abort = 1'b1;
      stall     = 1'b0;
      ex_mem_d  = '0;
    end
  end

  // Gated by rst_n so stall drops the moment reset asserts.
  assign stall_e = stall && rst_n;
`else
  // Every valid, unflushed instruction retires in one cycle.
  always_comb begin
    ex_mem_d = '0;
    if (valid_e && !flush_e) ex_mem_d = alu_slot;
  end

  assign stall_e = 1'b0;
`endif

  // EX/MEM pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_mem_q <= '0;
    else        ex_mem_q <= ex_mem_d;
  end

  assign pc_src_m         = ex_mem_q.pc_src;
  assign reg_write_m      = ex_mem_q.reg_write;
  assign mem_reg_m        = ex_mem_q.mem_reg;
  assign mem_write_m      = ex_mem_q.mem_write;
  assign alu_result_m     = ex_mem_q.alu_result;
  assign write_data_m     = ex_mem_q.write_data;
  assign write_register_m = ex_mem_q.write_register;

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage (MUL checks follow EXEC_MUL_EN).
module tb_execute_stage;
  import proc_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              valid_e, flush_e;
  logic              pc_src_e, reg_write_e, mem_reg_e, mem_write_e;
  logic [2:0]        alu_control_e;
  logic [DATA_W-1:0] src_a_e, src_b_e, write_data_e;
  logic [REG_W-1:0]  write_register_e;
  logic              stall_e, zero_e;
  logic              pc_src_m, reg_write_m, mem_reg_m, mem_write_m;
  logic [DATA_W-1:0] alu_result_m, write_data_m;
  logic [REG_W-1:0]  write_register_m;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .valid_e          (valid_e),
    .flush_e          (flush_e),
    .pc_src_e         (pc_src_e),
    .reg_write_e      (reg_write_e),
    .mem_reg_e        (mem_reg_e),
    .mem_write_e      (mem_write_e),
    .alu_control_e    (alu_control_e),
    .src_a_e          (src_a_e),
    .src_b_e          (src_b_e),
    .write_data_e     (write_data_e),
    .write_register_e (write_register_e),
    .stall_e          (stall_e),
    .zero_e           (zero_e),
    .pc_src_m         (pc_src_m),
    .reg_write_m      (reg_write_m),
    .mem_reg_m        (mem_reg_m),
    .mem_write_m      (mem_write_m),
    .alu_result_m     (alu_result_m),
    .write_data_m     (write_data_m),
    .write_register_m (write_register_m)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [DATA_W-1:0] a,
                       input logic [DATA_W-1:0] b, input logic rw, input logic [REG_W-1:0] wr);
    valid_e          = v;
    flush_e          = 1'b0;
    pc_src_e         = 1'b0;
    reg_write_e      = rw;
    mem_reg_e        = 1'b0;
    mem_write_e      = 1'b0;
    alu_control_e    = op;
    src_a_e          = a;
    src_b_e          = b;
    write_data_e     = '0;
    write_register_e = wr;
  endtask

  function automatic logic [3:0] ctrl_m();
    return {pc_src_m, reg_write_m, mem_reg_m, mem_write_m};
  endfunction

`ifdef EXEC_MUL_EN
  // Presents a MUL until stall_e drops, then checks stall length, bubbles and the result.
  task automatic run_mul(input string tag, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input logic [DATA_W-1:0] exp);
    int   stall_cnt = 0;
    logic bad_bubble = 1'b0;
    drive(1'b1, 3'b111, a, b, 1'b1, 4'd5);
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!stall_e) break;
      stall_cnt++;
      tick();
      if (ctrl_m() !== 4'b0000) bad_bubble = 1'b1;
    end
    chk({tag, "_stall_cycles"}, stall_cnt, 12);
    chk({tag, "_bubbles"}, bad_bubble, 1'b0);
    tick();
    chk({tag, "_result"}, alu_result_m, exp);
    chk({tag, "_reg_write"}, reg_write_m, 1'b1);
    chk({tag, "_dest"}, write_register_m, 4'd5);
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 3'b111, 22'($urandom), 22'($urandom), 1'b1, 4'($urandom));
    pc_src_e = 1'b1; mem_write_e = 1'b1; write_data_e = 22'($urandom);
    repeat (3) tick();
    chk("reset_ctrl", ctrl_m(), 4'b0000);
    chk("reset_result", alu_result_m, 0);
    chk("reset_wdata", write_data_m, 0);
    chk("reset_dest", write_register_m, 0);
    chk("reset_stall", stall_e, 1'b0);

    rst_n = 1'b1;
    drive(1'b1, 3'b000, 22'd5, 22'd7, 1'b1, 4'd3);
    tick();
    chk("add_result", alu_result_m, 12);
    chk("add_reg_write", reg_write_m, 1'b1);
    chk("add_dest", write_register_m, 4'd3);

    drive(1'b1, 3'b000, 22'h3FFFFF, 22'd1, 1'b1, 4'd1);
    #1;
    chk("wrap_zero_e", zero_e, 1'b1);
    tick();
    chk("wrap_result", alu_result_m, 0);

    drive(1'b1, 3'b001, 22'd10, 22'd3, 1'b0, 4'd2);
    mem_write_e = 1'b1; write_data_e = 22'h155;
    #1;
    chk("sub_zero_e", zero_e, 1'b0);
    tick();
    chk("sub_result", alu_result_m, 7);
    chk("sub_ctrl", ctrl_m(), 4'b0001);
    chk("sub_wdata", write_data_m, 22'h155);

    drive(1'b1, 3'b100, 22'h0F0F0F, 22'h00FF00, 1'b1, 4'd4);
    tick();
    chk("xor_result", alu_result_m, 22'h0FF00F);

    drive(1'b1, 3'b101, 22'd1, 22'd21, 1'b1, 4'd4);
    tick();
    chk("sll21_result", alu_result_m, 22'h200000);

    drive(1'b1, 3'b110, 22'h3FFFFF, 22'd22, 1'b1, 4'd4);
    tick();
    chk("srl22_result", alu_result_m, 0);

    drive(1'b1, 3'b110, 22'h3FFFFF, 22'd4, 1'b1, 4'd4);
    tick();
    chk("srl4_result", alu_result_m, 22'h03FFFF);

    drive(1'b0, 3'b000, 22'd1, 22'd2, 1'b1, 4'd6);
    tick();
    chk("invalid_bubble_ctrl", ctrl_m(), 4'b0000);
    chk("invalid_bubble_result", alu_result_m, 0);

    drive(1'b1, 3'b000, 22'd1, 22'd2, 1'b1, 4'd6);
    flush_e = 1'b1;
    tick();
    chk("flush_idle_ctrl", ctrl_m(), 4'b0000);

`ifdef EXEC_MUL_EN
    run_mul("mul1", 22'd1234, 22'd567, 22'd699678);
    run_mul("mul2", 22'h3FFFFF, 22'h3FFFFF, 22'd1);

    // Flush in cycle 5 of a MUL, then an ADD, then watch for a stale product.
    drive(1'b1, 3'b111, 22'd1234, 22'd567, 1'b1, 4'd5);
    repeat (5) tick();
    flush_e = 1'b1;
    #1;
    chk("flush_mul_stall", stall_e, 1'b0);
    tick();
    chk("flush_mul_bubble", ctrl_m(), 4'b0000);
    drive(1'b1, 3'b000, 22'd2, 22'd3, 1'b1, 4'd7);
    #1;
    chk("post_flush_stall", stall_e, 1'b0);
    tick();
    chk("post_flush_add", alu_result_m, 5);
    chk("post_flush_dest", write_register_m, 4'd7);
    begin
      logic stale = 1'b0;
      drive(1'b0, 3'b000, '0, '0, 1'b0, '0);
      repeat (16) begin
        tick();
        if (reg_write_m !== 1'b0 || alu_result_m !== '0) stale = 1'b1;
      end
      chk("no_stale_product", stale, 1'b0);
    end

    // Reset pulsed during BUSY.
    drive(1'b1, 3'b111, 22'd1234, 22'd567, 1'b1, 4'd5);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_stall", stall_e, 1'b0);
    chk("midreset_ctrl", ctrl_m(), 4'b0000);
    chk("midreset_result", alu_result_m, 0);
    drive(1'b0, 3'b000, '0, '0, 1'b0, '0);
    tick();
    rst_n = 1'b1;
    run_mul("mul3", 22'd3, 22'd4, 22'd12);
`else
    drive(1'b1, 3'b111, 22'd3, 22'd4, 1'b1, 4'd5);
    #1;
    chk("nomul_stall", stall_e, 1'b0);
    tick();
    chk("nomul_result", alu_result_m, 0);
    chk("nomul_reg_write", reg_write_m, 1'b1);
    chk("nomul_dest", write_register_m, 4'd5);
    chk("nomul_stall_after", stall_e, 1'b0);
`endif

    drive(1'b0, 3'b000, '0, '0, 1'b0, '0);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
